// File: rtl/countdown_timer.sv
// MM:SS down-counter with one-second prescaler and IDLE/RUN/PAUSE/DONE control.
// Optional COUNTDOWN_AUTO_RELOAD_EN: on expiry, reload the last loaded value and keep running.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned MAX_VAL  = 59
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [5:0] min_in,
  input  logic [5:0] sec_in,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       expired
);

  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [PreW-1:0] PreReload = PreW'(TICK_DIV - 1);
  localparam logic [5:0] MaxVal = 6'(MAX_VAL);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e          state_q, state_d;
  logic [5:0]      min_q, min_d, sec_q, sec_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            running_q, done_q;
  logic            tick, last_sec, expire_evt, load_evt, value_zero, reload_ok;

  function automatic logic [5:0] clamp(input logic [5:0] v);
    return (v > MaxVal) ? MaxVal : v;
  endfunction

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [5:0] shadow_min_q, shadow_sec_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_min_q <= '0;
      shadow_sec_q <= '0;
    end else if (load_evt) begin
      shadow_min_q <= clamp(min_in);
      shadow_sec_q <= clamp(sec_in);
    end
  end

  // A zero shadow value cannot restart the count, so expiry falls through to DONE.
  assign reload_ok = (shadow_min_q != '0) || (shadow_sec_q != '0);
`else
  assign reload_ok = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!load && start && !value_zero) state_d = StRun;
      end
      StRun: begin
        if (pause)           state_d = StPause;
        else if (expire_evt) state_d = reload_ok ? StRun : StDone;
      end
      StPause: begin
        if (load)                 state_d = StIdle;
        else if (start && !pause) state_d = StRun;
      end
      StDone: begin
        if (load) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Decoded control and outputs
  always_comb begin
    value_zero = (min_q == '0) && (sec_q == '0);
    last_sec   = (min_q == '0) && (sec_q == 6'd1);
    tick       = (state_q == StRun) && !pause && (presc_q == '0);
    expire_evt = tick && last_sec;
    load_evt   = load && (state_q != StRun);
    expired    = (state_q == StDone);
    running    = running_q;
    done       = done_q;
    minutes    = min_q;
    seconds    = sec_q;
  end

  // Datapath next-state
  always_comb begin
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    if (load_evt) begin
      min_d = clamp(min_in);
      sec_d = clamp(sec_in);
    end else if ((state_q == StIdle) && (state_d == StRun)) begin
      presc_d = PreReload;
    end else if (tick) begin
      presc_d = PreReload;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      if (expire_evt && reload_ok) begin
        min_d = shadow_min_q;
        sec_d = shadow_sec_q;
      end else
`endif
      if (sec_q != '0) begin
        sec_d = sec_q - 6'd1;
      end else begin
        sec_d = MaxVal;
        min_d = min_q - 6'd1;
      end
    end else if ((state_q == StRun) && !pause) begin
      presc_d = presc_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_q     <= '0;
      sec_q     <= '0;
      presc_q   <= PreReload;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      running_q <= (state_d == StRun);
      done_q    <= expire_evt;
    end
  end

endmodule
